// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// A one-cycle DONE state follows each frame, and a new request may be accepted in that cycle.
module uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             bit_end_s;

  // last clock of the current bit period
  always_comb begin
    bit_end_s = (baud_cnt_r == CNT_LAST);
  end

  // frame sequencer; tx, tx_busy and tx_done are all registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          tx_done <= 1'b0;
          if (tx_start) begin
            state_r    <= START;
            shift_r    <= tx_data;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r    <= DATA;
            baud_cnt_r <= '0;
            tx         <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              tx      <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx        <= shift_r[bit_idx_r + 3'd1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            state_r    <= DONE;
            baud_cnt_r <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          // unreachable encodings fall back to a quiet idle line
          state_r    <= IDLE;
          baud_cnt_r <= '0;
          bit_idx_r  <= 3'd0;
          tx         <= 1'b1;
          tx_busy    <= 1'b0;
          tx_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at 10 clocks per bit.
// Expected bytes are queued when a request is driven and popped when the frame is observed.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_tests;
  int n_fail;
  logic [7:0] sb_q[$];

  uart_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns #1 after the DONE edge.
  task automatic frame_check(input string tag);
    logic [7:0] exp;
    logic [9:0] fw;
    logic [9:0] mid;
    int bad_cycles;
    int bad_flags;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    fw  = {1'b1, exp, 1'b0};
    mid = 10'd0;
    bad_cycles = 0;
    bad_flags  = 0;
    check({tag, "_start_latency"}, 32'(tx), 32'd0);
    for (int c = 0; c < 100; c++) begin
      if (tx !== fw[c / 10]) bad_cycles++;
      if ((c % 10) == 5) mid[c / 10] = tx;
      if (tx_done !== 1'b0 || tx_busy !== 1'b1) bad_flags++;
      step();
    end
    check({tag, "_midpoints"}, 32'(mid), 32'(fw));
    check({tag, "_bit_timing"}, 32'(bad_cycles), 32'd0);
    check({tag, "_busy_done_in_frame"}, 32'(bad_flags), 32'd0);
    check({tag, "_done_pulse"}, 32'(tx_done), 32'd1);
    check({tag, "_done_busy"}, 32'(tx_busy), 32'd0);
    check({tag, "_done_tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    int bad;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // reset and idle
    step(); step(); step();
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("idle_50", 32'(bad), 32'd0);

    // single pulse, data changed right after accept
    tx_data = 8'hA5; tx_start = 1'b1; sb_q.push_back(8'hA5);
    step();
    tx_start = 1'b0; tx_data = 8'h5A;
    frame_check("a5");
    step();
    check("a5_after_done", 32'(tx_done), 32'd0);
    check("a5_back_idle", 32'({tx, tx_busy}), 32'd2);

    // request held through the frame with new data: second frame starts in DONE
    tx_data = 8'h3C; tx_start = 1'b1; sb_q.push_back(8'h3C);
    step();
    tx_data = 8'hFF; sb_q.push_back(8'hFF);
    frame_check("3c");
    step();
    tx_start = 1'b0;
    frame_check("ff");
    step();
    check("ff_back_idle", 32'({tx, tx_busy, tx_done}), 32'd4);

    // continuous stream of zeros
    tx_data = 8'h00; tx_start = 1'b1;
    sb_q.push_back(8'h00); sb_q.push_back(8'h00); sb_q.push_back(8'h00);
    step();
    frame_check("z0");
    step();
    frame_check("z1");
    step();
    frame_check("z2");
    tx_start = 1'b0;
    step();
    check("z_back_idle", 32'({tx, tx_busy, tx_done}), 32'd4);

    // reset mid-frame aborts without a done pulse
    tx_data = 8'h81; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < 45; i++) step();
    check("abort_in_frame_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    step();
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    check("abort_quiet", 32'(bad), 32'd0);
    tx_data = 8'h81; tx_start = 1'b1; sb_q.push_back(8'h81);
    step();
    tx_start = 1'b0;
    frame_check("81_clean");
    step();

    // reset wins over a simultaneous request
    rst = 1'b1; tx_start = 1'b1; tx_data = 8'h55;
    step();
    rst = 1'b0; tx_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      step();
    end
    check("rst_priority", 32'(bad), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
